// File: rtl/apb_pkg.sv
// Shared types and constants for the round-robin APB master.
//   apb_state_e : APB sequencer state (IDLE / SETUP / ACCESS)
//   AW_DEFAULT, DW_DEFAULT : default address / data widths
//   idx_w()     : width of a binary index able to address n items (min 1)
package apb_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-requester request vector
//   en    : arbitration enable; grant is all-zero when low
//   last  : index granted most recently; search starts at last+1 (mod NREQ)
//   grant : one-hot winner
//   idx   : binary index of the winner (0 when nothing granted)
module rr_arbiter
    import apb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    int unsigned   cand_int;
    logic [IW-1:0] cand;
    logic          found;

    // Walk the requesters starting just after the previous winner; the
    // previous winner itself is visited last.
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand_int = 32'(last) + i;
            if (cand_int >= NREQ) begin
                cand_int = cand_int - NREQ;
            end
            cand = IW'(cand_int);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB3 master: grants one of NREQ requesters, runs the
// SETUP/ACCESS sequence with wait states and an ACCESS timeout, and returns
// a tagged response.
//   clk, rst_n                    : clock, async active-low reset
//   req_valid_i/write_i/addr_i/wdata_i : packed per-requester commands
//   grant_o                       : one-hot acceptance pulse (decoded in IDLE)
//   rsp_valid_o/id_o/rdata_o/err_o: registered completion pulse
//   psel_o..pwdata_o              : APB master outputs
//   prdata_i, pready_i, pslverr_i : APB slave response
module apb_rr_master
    import apb_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned AW      = AW_DEFAULT,
    parameter  int unsigned DW      = DW_DEFAULT,
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned IW      = idx_w(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ-1:0]    req_write_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    grant_o,
    output logic               rsp_valid_o,
    output logic [IW-1:0]      rsp_id_o,
    output logic [DW-1:0]      rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [AW-1:0]      paddr_o,
    output logic [DW-1:0]      pwdata_o,
    input  logic [DW-1:0]      prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    localparam int unsigned CW = idx_w(TIMEOUT);

    apb_state_e    state_q, state_d;
    logic [IW-1:0] last_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_en;

    logic          done;
    logic          err_d;
    logic [DW-1:0] rdata_d;

    logic          psel_q, penable_q, pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [IW-1:0] rsp_id_q;
    logic [DW-1:0] rsp_rdata_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid_i),
        .en    (arb_en),
        .last  (last_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Next state, timeout count and completion status.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arb_en  = 1'b0;
        done    = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (|req_valid_i) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // pready takes precedence over a coinciding timeout
                if (pready_i) begin
                    done    = 1'b1;
                    err_d   = pslverr_i;
                    rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done    = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (|arb_grant) begin
                last_q <= arb_idx;
            end
        end
    end

    // APB outputs; command captured at grant and held until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= (state_d != IDLE);
            penable_q <= (state_d == ACCESS);
            if (|arb_grant) begin
                pwrite_q <= req_write_i[arb_idx];
                paddr_q  <= req_addr_i[arb_idx*AW +: AW];
                pwdata_q <= req_wdata_i[arb_idx*DW +: DW];
            end
        end
    end

    // Completion pulse; last_q still holds the in-flight requester index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done;
            rsp_err_q   <= done & err_d;
            rsp_rdata_q <= done ? rdata_d : '0;
            if (done) begin
                rsp_id_q <= last_q;
            end
        end
    end

    assign grant_o     = arb_grant;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Testbench for apb_rr_master: directed scenarios plus randomized transfers
// checked against a round-robin / APB timing reference model.
module tb_apb_rr_master;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   grant_o;
    logic              rsp_valid_o;
    logic [1:0]        rsp_id_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [AW-1:0]     paddr_o;
    logic [DW-1:0]     pwdata_o;
    logic [DW-1:0]     prdata;
    logic              pready, pslverr;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int last_g;
    int gq[$];

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .grant_o     (grant_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        repeat (2) tick();
        check("rst_grant", grant_o, 0);
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_paddr", paddr_o, 0);
        check("rst_pwdata", pwdata_o, 0);
        check("rst_rdata_err", {rsp_rdata_o, rsp_err_o, rsp_id_o, pwrite_o}, 0);
        rst_n  = 1'b1;
        last_g = NREQ - 1;
    endtask

    // One full transfer starting in an IDLE cycle with at least one request.
    // waits >= TO means the slave never answers.
    task automatic xfer(input int waits, input bit slverr, input logic [31:0] rd, input bit drop);
        int            w, n_acc;
        bit            ready_end;
        logic [3:0]    eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic          ewr;
        #1;
        w = rr_pick(req_valid);
        if (w < 0) begin
            check("no_request_for_xfer", 1, 0);
            return;
        end
        eg = 4'(1 << w);
        check("grant", grant_o, eg);
        check("psel_at_grant", psel_o, 0);
        ea  = req_addr[w*AW +: AW];
        ew  = req_wdata[w*DW +: DW];
        ewr = req_write[w];
        last_g = w;
        gq.push_back(w);
        tick();
        // later input changes must not disturb the captured command
        req_addr[w*AW +: AW]  = $urandom;
        req_wdata[w*DW +: DW] = $urandom;
        req_write[w]          = ~req_write[w];
        if (drop) req_valid[w] = 1'b0;
        check("setup_psel", psel_o, 1);
        check("setup_penable", penable_o, 0);
        check("setup_paddr", paddr_o, ea);
        check("setup_pwrite", pwrite_o, ewr);
        check("setup_pwdata", pwdata_o, ew);
        check("setup_grant", grant_o, 0);
        check("setup_rsp_valid", rsp_valid_o, 0);
        tick();
        ready_end = (waits < TO);
        n_acc     = ready_end ? waits + 1 : TO;
        for (int k = 0; k < n_acc; k++) begin
            pready  = ready_end && (k == n_acc - 1);
            pslverr = slverr;
            prdata  = (k == n_acc - 1) ? rd : $urandom;
            check("acc_psel", psel_o, 1);
            check("acc_penable", penable_o, 1);
            check("acc_paddr", paddr_o, ea);
            check("acc_pwdata", pwdata_o, ew);
            check("acc_pwrite", pwrite_o, ewr);
            check("acc_rsp_valid", rsp_valid_o, 0);
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_id", rsp_id_o, w);
        check("rsp_err", rsp_err_o, ready_end ? slverr : 1'b1);
        check("rsp_rdata", rsp_rdata_o, (ready_end && !slverr && !ewr) ? rd : 32'h0);
        check("rsp_psel", psel_o, 0);
        check("rsp_penable", penable_o, 0);
    endtask

    initial begin
        int order_a[4];
        int order_b[4];
        bit drop;
        int r, waits;
        order_a = '{0, 1, 2, 3};
        order_b = '{0, 2, 3, 0};
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        do_reset();

        // single read from requester 1
        req_valid = 4'b0010;
        req_write = 4'b0000;
        req_addr[1*AW +: AW] = 32'h1000;
        xfer(0, 1'b0, 32'hCAFE0001, 1'b1);

        // idle: no requests, no grant, bus stays quiet
        req_valid = '0;
        #1;
        check("idle_grant", grant_o, 0);
        tick();
        check("idle_psel", psel_o, 0);
        check("idle_rsp_valid", rsp_valid_o, 0);

        // round robin with everyone requesting, then requester 1 withdraws
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
        end
        req_valid = 4'b1111;
        gq.delete();
        for (int i = 0; i < 4; i++) xfer($urandom_range(0, 2), 1'b0, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) check("rr_order_all", gq[i], order_a[i]);
        req_valid[1] = 1'b0;
        gq.delete();
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) check("rr_order_skip1", gq[i], order_b[i]);

        // write with 3 wait states
        req_valid = 4'b0100;
        req_write[2] = 1'b1;
        req_addr[2*AW +: AW]  = 32'h20;
        req_wdata[2*DW +: DW] = 32'h12345678;
        xfer(3, 1'b0, 32'hDEADBEEF, 1'b1);

        // timeout: slave never ready
        req_valid = 4'b0001;
        req_write[0] = 1'b0;
        xfer(TO + 5, 1'b0, 32'h55AA55AA, 1'b1);
        #1;
        check("after_timeout_idle", psel_o, 0);

        // slave error on read
        req_valid = 4'b1000;
        req_write[3] = 1'b0;
        xfer(0, 1'b1, 32'h0BADF00D, 1'b1);

        // pready on the very last allowed ACCESS cycle wins over timeout
        req_valid = 4'b0010;
        req_write[1] = 1'b0;
        xfer(TO - 1, 1'b0, 32'hA5A5A5A5, 1'b1);

        // randomized transfers
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                #1;
                check("rnd_idle_grant", grant_o, 0);
                tick();
                check("rnd_idle_psel", psel_o, 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                req_addr[i*AW +: AW]  = $urandom;
                req_wdata[i*DW +: DW] = $urandom;
                req_write[i]          = 1'($urandom_range(0, 1));
            end
            req_valid = 4'($urandom_range(1, 15));
            r     = $urandom_range(0, 9);
            waits = (r == 9) ? TO + 2 : r % 5;
            drop  = 1'($urandom_range(0, 1));
            xfer(waits, ($urandom_range(0, 3) == 0), $urandom, drop);
        end

        // reset during ACCESS
        req_valid = 4'b1000;
        #1;
        check("rstmid_grant", grant_o, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        check("rstmid_penable_before", penable_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_psel_async", psel_o, 0);
        check("rstmid_penable_async", penable_o, 0);
        check("rstmid_rsp_valid", rsp_valid_o, 0);
        repeat (2) begin
            tick();
            check("rstmid_no_rsp", rsp_valid_o, 0);
        end
        rst_n  = 1'b1;
        last_g = NREQ - 1;
        tick();
        check("rstmid_after_no_rsp", rsp_valid_o, 0);
        req_valid = 4'b1111;
        gq.delete();
        xfer(1, 1'b0, $urandom, 1'b1);
        check("rstmid_first_winner", gq[0], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
